// File: rtl/scan_pkg.sv
// Shared constants, FSM state type and nibble helpers for the digit scan sequencer.
// No logic of its own; no latency; no backpressure.
// Imported by digit_scan_ctrl and tick_div.
package scan_pkg;

  localparam int DIGITS = 4;
  localparam int SEL_W  = 2;
  localparam int NIB_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // Prescaler width; a one-cycle dwell still needs a one-bit counter.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic [NIB_W-1:0] nib_of(input logic [DIGITS*NIB_W-1:0] d,
                                              input logic [SEL_W-1:0]        s);
    logic [NIB_W-1:0] r;
    r = '0;
    case (s)
      2'd0:    r = d[3:0];
      2'd1:    r = d[7:4];
      2'd2:    r = d[11:8];
      default: r = d[15:12];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_tick_div.sv
// Dwell prescaler: counts 0..CLK_DIV-1 while enabled, sync clear has priority.
// tc is combinational from the count, asserted during the last cycle of a dwell.
// No backpressure; counting is gated only by en.
module tick_div
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = cnt_width(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_term;

  assign at_term = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = en && !clr && at_term;

endmodule

// File: rtl/digit_scan_ctrl.sv
// 4-digit display scan sequencer: cycles sel/sel_en/nibble, pulses frame_done on 3->0 wrap.
// All outputs registered; sel_en first valid one cycle after run is sampled. Optional SCAN_BLANK_EN.
// No backpressure; data/mask are sampled only at run start and at frame boundaries.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [DIGITS*NIB_W-1:0] data,
  input  logic [DIGITS-1:0]       mask,
  output logic [SEL_W-1:0]        sel,
  output logic                    sel_en,
  output logic [NIB_W-1:0]        nibble,
  output logic                    frame_done
);

  localparam int CNT_W = cnt_width(CLK_DIV);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    sel_en_q, sel_en_d;
  logic [NIB_W-1:0]        nibble_q, nibble_d;
  logic                    frame_done_q, frame_done_d;
  logic [DIGITS*NIB_W-1:0] data_q, data_d;
  logic [DIGITS-1:0]       mask_q, mask_d;

  logic             showing;
  logic             tick_clr, tick_en, tick_tc;
  logic [CNT_W-1:0] presc;

  // The prescaler only runs while scanning; any other cycle parks it at 0.
  assign tick_en  = (state_q == SHOW) && run;
  assign tick_clr = !tick_en;

  tick_div #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .en    (tick_en),
    .cnt   (presc),
    .tc    (tick_tc)
  );

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLK = CNT_W'(BLANK_CYC);
  logic [CNT_W-1:0] presc_nxt;
  assign presc_nxt = (tick_clr || tick_tc) ? '0 : presc + CNT_W'(1);
`else
  logic unused_blank;
  assign unused_blank = ^{presc, BLANK_CYC[0]};
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    data_d       = data_q;
    mask_d       = mask_q;
    frame_done_d = 1'b0;
    showing      = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (run) begin
          state_d = SHOW;
          data_d  = data;
          mask_d  = mask;
          showing = 1'b1;
        end
      end
      SHOW: begin
        if (!run) begin
          // Dropping run beats a coincident wrap: no frame_done on the way out.
          state_d = IDLE;
          sel_d   = '0;
        end else begin
          showing = 1'b1;
          if (tick_tc) begin
            sel_d = sel_q + SEL_W'(1);
            if (sel_q == SEL_W'(DIGITS - 1)) begin
              frame_done_d = 1'b1;
              data_d       = data;
              mask_d       = mask;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    // Outputs are computed from next-state values so they line up with sel.
    nibble_d = showing ? nib_of(data_d, sel_d) : '0;
    sel_en_d = showing && !mask_d[sel_d];
`ifdef SCAN_BLANK_EN
    if (presc_nxt < BLK) begin
      sel_en_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      nibble_q     <= '0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign nibble     = nibble_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with CLK_DIV=4, BLANK_CYC=1.
// Observed vector per cycle is {sel, sel_en, nibble, frame_done}.
module tb_digit_scan_ctrl;

`ifdef SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] data;
  logic [3:0]  mask;
  logic [1:0]  sel;
  logic        sel_en;
  logic [3:0]  nibble;
  logic        frame_done;

  int vectors = 0;
  int errors  = 0;

  digit_scan_ctrl #(
    .CLK_DIV   (4),
    .BLANK_CYC (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .data       (data),
    .mask       (mask),
    .sel        (sel),
    .sel_en     (sel_en),
    .nibble     (nibble),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [3:0] nib(input logic [15:0] d, input int s);
    logic [15:0] t;
    t = d >> (4 * s);
    return t[3:0];
  endfunction

  function automatic logic en_exp(input logic [3:0] m, input int s, input int cnt);
    return !m[2'(s)] && !(cnt < BLANK);
  endfunction

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b1; run = 1'b0; data = '0; mask = '0;
    #1 rst_n = 1'b0;
    #2;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_async got=%h exp=00", obs); end
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_held got=%h exp=00", obs); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle got=%h exp=00", obs); end
  endtask

  task automatic test_scan(input logic [3:0] m, input string tag);
    logic [7:0] obs, exp;
    int s, c;
    data = 16'hA5C3; mask = m; run = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      s = (k / 4) % 4; c = k % 4;
      exp = {2'(s), en_exp(m, s, c), nib(16'hA5C3, s), (k == 16)};
      obs = {sel, sel_en, nibble, frame_done}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL %s k=%0d got=%h exp=%h", tag, k, obs, exp); end
    end
    run = 1'b0;
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL %s_stop got=%h exp=00", tag, obs); end
  endtask

  task automatic test_data_change();
    logic [7:0] obs, exp;
    int s, c;
    data = 16'hA5C3; mask = 4'h0; run = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      @(posedge clk); #1;
      s = (k / 4) % 4; c = k % 4;
      exp = {2'(s), en_exp(4'h0, s, c), nib((k < 16) ? 16'hA5C3 : 16'h1234, s),
             (k == 16 || k == 32)};
      obs = {sel, sel_en, nibble, frame_done}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL data_change k=%0d got=%h exp=%h", k, obs, exp); end
      if (k == 4) data = 16'h1234;
    end
    run = 1'b0;
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL data_change_stop got=%h exp=00", obs); end
  endtask

  task automatic test_run_drop();
    logic [7:0] obs, exp;
    int s, c;
    data = 16'hA5C3; mask = 4'h0; run = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #1;
      s = k / 4; c = k % 4;
      exp = {2'(s), en_exp(4'h0, s, c), nib(16'hA5C3, s), 1'b0};
      obs = {sel, sel_en, nibble, frame_done}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL run_drop k=%0d got=%h exp=%h", k, obs, exp); end
    end
    run = 1'b0;
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL run_drop_mid got=%h exp=00", obs); end
    // Restart samples fresh data, then drop run exactly on the wrap edge.
    data = 16'h1234; run = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(posedge clk); #1;
      s = k / 4; c = k % 4;
      exp = {2'(s), en_exp(4'h0, s, c), nib(16'h1234, s), 1'b0};
      obs = {sel, sel_en, nibble, frame_done}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL restart k=%0d got=%h exp=%h", k, obs, exp); end
    end
    run = 1'b0;
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL run_drop_wrap got=%h exp=00", obs); end
  endtask

  task automatic test_async_reset();
    logic [7:0] obs, exp;
    int s, c;
    data = 16'hA5C3; mask = 4'h0; run = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      s = k / 4; c = k % 4;
      exp = {2'(s), en_exp(4'h0, s, c), nib(16'hA5C3, s), 1'b0};
      obs = {sel, sel_en, nibble, frame_done}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs, exp); end
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL mid_reset got=%h exp=00", obs); end
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL mid_reset_held got=%h exp=00", obs); end
    rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      s = k / 4; c = k % 4;
      exp = {2'(s), en_exp(4'h0, s, c), nib(16'hA5C3, s), 1'b0};
      obs = {sel, sel_en, nibble, frame_done}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, obs, exp); end
    end
    run = 1'b0;
    @(posedge clk); #1;
    obs = {sel, sel_en, nibble, frame_done}; vectors++;
    if (obs !== 8'h00) begin errors++; $display("FAIL post_reset_stop got=%h exp=00", obs); end
  endtask

  initial begin
    test_reset();
    test_scan(4'b0000, "scan");
    test_scan(4'b0100, "mask");
    test_scan(4'b1111, "mask_all");
    test_data_change();
    test_run_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
